// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_ctrl_pkg
// Desc   : Shared FSM states, owner tags and mem_len codes for mem_ctrl.
// Rev    : 1.0
// ============================================================================
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam logic [1:0] c_LEN_B        = 2'b00;
  localparam logic [1:0] c_LEN_H        = 2'b01;
  localparam logic [1:0] c_LEN_W        = 2'b10;
  localparam logic [2:0] c_FETCH_BYTES  = 3'd4;

  // Code 2'b11 is deliberately folded into the word case.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      c_LEN_B: return 3'd1;
      c_LEN_H: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mem_ctrl
// Desc   : Byte-serial RAM port arbiter for instruction fetch and load/store.
// Rev    : 1.0
// ============================================================================
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic              mem_done,
  output logic [XLEN-1:0]   mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_base;
  logic [2:0]        r_len;
  logic [2:0]        r_cnt;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_buf;
  logic [XLEN-1:0]   r_if_rdata;
  logic [XLEN-1:0]   r_mem_rdata;
  logic [XLEN-1:0]   w_assembled;
  logic [1:0]        w_lane;
  logic              w_grant_mem;
  logic              w_grant_if;
  logic              w_if_flushing;
  logic              w_unused;

  assign w_unused      = ^{if_addr[XLEN-1:ADDR_W], mem_addr[XLEN-1:ADDR_W]};
  assign w_if_flushing = (r_owner == OWN_IF) && if_flush;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req) begin
          w_grant_mem = 1'b1;
          w_state_nxt = mem_we ? ST_WR : ST_RD;
        end else if (if_req && !if_flush) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        if (w_if_flushing)
          w_state_nxt = ST_IDLE;
        else if (r_cnt == r_len)
          w_state_nxt = ST_DONE;
      end
      ST_WR: begin
        if (r_cnt == r_len - 3'd1)
          w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // RAM data lags the address by one cycle, so count k delivers byte k-1.
  assign w_lane = r_cnt[1:0] - 2'd1;

  always_comb begin
    w_assembled = r_buf;
    if (r_cnt != 3'd0)
      w_assembled[{w_lane, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_base      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_mem || w_grant_if) begin
        r_owner <= w_grant_mem ? OWN_MEM : OWN_IF;
        r_base  <= w_grant_mem ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
        r_len   <= w_grant_mem ? len_bytes(mem_len) : c_FETCH_BYTES;
        r_wdata <= mem_wdata;
        r_cnt   <= '0;
        r_buf   <= '0;
      end else if (r_state == ST_RD || r_state == ST_WR) begin
        r_cnt <= r_cnt + 3'd1;
        if (r_state == ST_RD)
          r_buf <= w_assembled;
      end
      if (r_state == ST_RD && w_state_nxt == ST_DONE) begin
        if (r_owner == OWN_IF)
          r_if_rdata <= w_assembled;
        else
          r_mem_rdata <= w_assembled;
      end
    end
  end

  always_comb begin
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = '0;
    if (r_state == ST_RD || r_state == ST_WR)
      ram_a = r_base + ADDR_W'(r_cnt);
    if (r_state == ST_WR) begin
      ram_wr   = 1'b1;
      ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
    end
  end

  // A redirect arriving in the DONE cycle must still kill the fetch result.
  assign if_done   = (r_state == ST_DONE) && (r_owner == OWN_IF) && !if_flush;
  assign mem_done  = (r_state == ST_DONE) && (r_owner == OWN_MEM);
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;

endmodule
`default_nettype wire
